// File: rtl/uart_mmio_pkg.sv
// Shared constants, decode select type and helpers for the UART MMIO controller.
// Optional transmit counter is enabled by defining UART_TX_CNT_EN.
package uart_mmio_pkg;

   localparam logic [31:0] UART_CTRL_OFS = 32'h0000_0000;
   localparam logic [31:0] UART_STAT_OFS = 32'h0000_0004;
   localparam logic [31:0] UART_TX_OFS   = 32'h0000_0008;
   localparam logic [31:0] UART_RX_OFS   = 32'h0000_000C;
   localparam logic [31:0] UART_CNT_OFS  = 32'h0000_0010;

   localparam int unsigned CTRL_TX_NOT_FULL_BIT = 0;
   localparam int unsigned STAT_RX_FULL_BIT     = 0;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_CTRL,
      SEL_STAT,
      SEL_TX,
      SEL_RX,
      SEL_CNT
   } reg_sel_e;

   function automatic logic [31:0] sext8(input logic [7:0] b);
      return {{24{b[7]}}, b};
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter; registered storage, power-of-two depth.
module uart_tx_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic [7:0] wdata,
   input  logic       pop,
   output logic       full,
   output logic       empty,
   output logic [7:0] head
);
   import uart_mmio_pkg::*;

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    mem_d [DEPTH];
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count_q == DEPTH_C);
   assign empty   = (count_q == '0);
   assign head    = mem_q[rd_ptr_q];
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      if (push_ok && !pop_ok) begin
         count_d = count_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         mem_q    <= '{default: '0};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// CPU-facing register window for the UART: TX FIFO, RX holding register, registered loads.
// Defining UART_TX_CNT_EN adds a clearable transmitted-byte counter at +0x10.
module uart_mmio_ctrl #(
   parameter int unsigned TX_DEPTH  = 4,
   parameter logic [31:0] ADDR_BASE = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] addr,
   input  logic        memRd,
   input  logic        memWr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        stall,
   output logic [7:0]  DataIn,
   output logic        DataInValid,
   input  logic        DataInReady,
   input  logic [7:0]  DataOut,
   input  logic        DataOutValid,
   output logic        DataOutReady
);
   import uart_mmio_pkg::*;

   reg_sel_e    sel;
   logic        rd_en;
   logic        tx_push;
   logic        tx_pop;
   logic        tx_full;
   logic        tx_empty;
   logic        rx_capture;
   logic        rx_pop;
   logic        rx_full_q, rx_full_d;
   logic [7:0]  rx_buf_q, rx_buf_d;
   logic [31:0] rdata_q, rdata_d;
   logic        unused_wdata;

   assign unused_wdata = ^wdata[31:8];

   always_comb begin
      sel = SEL_NONE;
      if (addr == ADDR_BASE + UART_CTRL_OFS) sel = SEL_CTRL;
      if (addr == ADDR_BASE + UART_STAT_OFS) sel = SEL_STAT;
      if (addr == ADDR_BASE + UART_TX_OFS)   sel = SEL_TX;
      if (addr == ADDR_BASE + UART_RX_OFS)   sel = SEL_RX;
      if (addr == ADDR_BASE + UART_CNT_OFS)  sel = SEL_CNT;
   end

   // A simultaneous store suppresses the load and all of its side effects.
   assign rd_en       = memRd & ~memWr;
   assign tx_push     = memWr & (sel == SEL_TX);
   assign stall       = tx_push & tx_full;
   assign DataInValid = ~tx_empty;
   assign tx_pop      = DataInValid & DataInReady;

   uart_tx_fifo #(
      .DEPTH (TX_DEPTH)
   ) u_tx_fifo (
      .clk   (clk),
      .rst_n (reset_n),
      .push  (tx_push),
      .wdata (wdata[7:0]),
      .pop   (tx_pop),
      .full  (tx_full),
      .empty (tx_empty),
      .head  (DataIn)
   );

   assign DataOutReady = ~rx_full_q;
   assign rx_capture   = DataOutValid & ~rx_full_q;
   assign rx_pop       = rd_en & (sel == SEL_RX) & rx_full_q;

   always_comb begin
      rx_full_d = rx_full_q;
      rx_buf_d  = rx_buf_q;
      if (rx_capture) begin
         rx_full_d = 1'b1;
         rx_buf_d  = DataOut;
      end else if (rx_pop) begin
         rx_full_d = 1'b0;
      end
   end

`ifdef UART_TX_CNT_EN
   logic [31:0] tx_cnt_q, tx_cnt_d;

   always_comb begin
      tx_cnt_d = tx_cnt_q;
      if (memWr && (sel == SEL_CNT)) begin
         tx_cnt_d = '0;
      end else if (tx_pop) begin
         tx_cnt_d = tx_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) tx_cnt_q <= '0;
      else          tx_cnt_q <= tx_cnt_d;
   end
`endif

   always_comb begin
      rdata_d = '0;
      if (rd_en) begin
         case (sel)
            SEL_CTRL: rdata_d[CTRL_TX_NOT_FULL_BIT] = ~tx_full;
            SEL_STAT: rdata_d[STAT_RX_FULL_BIT]     = rx_full_q;
            SEL_RX:   rdata_d = rx_full_q ? sext8(rx_buf_q) : '0;
`ifdef UART_TX_CNT_EN
            SEL_CNT:  rdata_d = tx_cnt_q;
`endif
            default:  rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_full_q <= 1'b0;
         rx_buf_q  <= '0;
         rdata_q   <= '0;
      end else begin
         rx_full_q <= rx_full_d;
         rx_buf_q  <= rx_buf_d;
         rdata_q   <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Scoreboard bench for uart_mmio_ctrl against a queue-based model of the register window.
module tb_uart_mmio_ctrl;

   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] BASE  = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] addr;
   logic        memRd;
   logic        memWr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        stall;
   logic [7:0]  DataIn;
   logic        DataInValid;
   logic        DataInReady;
   logic [7:0]  DataOut;
   logic        DataOutValid;
   logic        DataOutReady;

   uart_mmio_ctrl #(
      .TX_DEPTH  (DEPTH),
      .ADDR_BASE (BASE)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .addr         (addr),
      .memRd        (memRd),
      .memWr        (memWr),
      .wdata        (wdata),
      .rdata        (rdata),
      .stall        (stall),
      .DataIn       (DataIn),
      .DataInValid  (DataInValid),
      .DataInReady  (DataInReady),
      .DataOut      (DataOut),
      .DataOutValid (DataOutValid),
      .DataOutReady (DataOutReady)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic [31:0] rd_sb [$];
   logic [7:0]  tx_sb [$];

   int          occ = 0;
   bit          m_rx_full = 0;
   logic [7:0]  m_rx_byte = '0;
   logic [31:0] m_cnt = '0;
   bit          last_stall = 0;

   logic        tb_rdy = 0;
   logic        tb_ov = 0;
   logic [7:0]  tb_od = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (rd_sb.size() > 0) begin
            automatic logic [31:0] e = rd_sb.pop_front();
            chk("rdata", rdata, e);
         end
         if (reset_n && DataInValid && DataInReady) begin
            if (tx_sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL tx_spurious: got byte %h, expected none", DataIn);
            end else begin
               automatic logic [7:0] b = tx_sb.pop_front();
               chk("DataIn", {24'd0, DataIn}, {24'd0, b});
            end
         end
      end
   end

   task automatic step(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic rdy, input logic ov,
                       input logic [7:0] od);
      logic [31:0] exp_rd;
      bit          acc, pop, rx_pop, cap, exp_stall;
      #1;
      memRd = rd; memWr = wr; addr = a; wdata = wd;
      DataInReady = rdy; DataOutValid = ov; DataOut = od;
      @(negedge clk);
      exp_stall = wr && (a == BASE + 32'h8) && (occ == DEPTH);
      chk("stall", {31'd0, stall}, {31'd0, exp_stall});
      chk("DataInValid", {31'd0, DataInValid}, {31'd0, occ > 0});
      chk("DataOutReady", {31'd0, DataOutReady}, {31'd0, !m_rx_full});
      @(posedge clk);
      exp_rd = '0;
      if (rd && !wr) begin
         if (a == BASE)                 exp_rd = (occ < DEPTH) ? 32'd1 : 32'd0;
         else if (a == BASE + 32'h4)    exp_rd = m_rx_full ? 32'd1 : 32'd0;
         else if (a == BASE + 32'hC)    exp_rd = m_rx_full ? 32'($signed(m_rx_byte)) : 32'd0;
`ifdef UART_TX_CNT_EN
         else if (a == BASE + 32'h10)   exp_rd = m_cnt;
`endif
      end
      pop = (occ > 0) && rdy;
      acc = wr && (a == BASE + 32'h8) && (occ < DEPTH);
      if (acc) tx_sb.push_back(wd[7:0]);
      occ = occ + int'(acc) - int'(pop);
      if (wr && (a == BASE + 32'h10)) m_cnt = '0;
      else if (pop)                   m_cnt = m_cnt + 32'd1;
      rx_pop = rd && !wr && (a == BASE + 32'hC) && m_rx_full;
      cap    = ov && !m_rx_full;
      if (rx_pop) m_rx_full = 0;
      if (cap) begin
         m_rx_full = 1;
         m_rx_byte = od;
      end
      rd_sb.push_back(exp_rd);
      last_stall = exp_stall;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, tb_rdy, tb_ov, tb_od);
   endtask

   task automatic rd(input logic [31:0] a);
      step(1'b1, 1'b0, a, '0, tb_rdy, tb_ov, tb_od);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      step(1'b0, 1'b1, a, d, tb_rdy, tb_ov, tb_od);
   endtask

   task automatic store_until(input logic [7:0] d);
      bit done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         wr(BASE + 32'h8, {24'hA5A5A5, d});
         if (!last_stall) done = 1;
      end
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL store_timeout: byte %h still stalled, expected accept", d);
      end
   endtask

   task automatic drain();
      tb_rdy = 1;
      for (int i = 0; i < 50 && occ != 0; i++) idle(1);
      if (occ != 0) begin
         tests++;
         fails++;
         $display("FAIL drain_timeout: %0d entries left, expected 0", occ);
      end
      idle(1);
   endtask

   initial begin
      logic [31:0] addrs [8];
      addrs = '{BASE, BASE + 32'h4, BASE + 32'h8, BASE + 32'hC, BASE + 32'h10,
                BASE + 32'h14, BASE + 32'h2, 32'h9000_0008};
      reset_n = 0; memRd = 0; memWr = 0; addr = '0; wdata = '0;
      DataInReady = 0; DataOutValid = 0; DataOut = '0;
      #23 reset_n = 1;
      @(posedge clk);

      rd(BASE);
      rd(BASE + 32'h4);

      tb_rdy = 0;
      for (int i = 0; i < 4; i++) wr(BASE + 32'h8, 32'h41 + i);
      wr(BASE + 32'h8, 32'h45);
      tb_rdy = 1;
      store_until(8'h45);
      drain();
      rd(BASE);

      tb_ov = 1; tb_od = 8'h9C;
      idle(1);
      tb_ov = 0;
      rd(BASE + 32'h4);
      rd(BASE + 32'hC);
      rd(BASE + 32'h4);
      rd(BASE + 32'hC);

      tb_ov = 1; tb_od = 8'h7F;
      idle(1);
      tb_od = 8'h12;
      idle(3);
      rd(BASE + 32'hC);
      idle(1);
      tb_ov = 0;
      rd(BASE + 32'hC);

      tb_rdy = 0;
      wr(BASE + 32'h8, 32'h60);
      wr(BASE + 32'h8, 32'h61);
      tb_rdy = 1;
      wr(BASE + 32'h8, 32'h55);
      tb_rdy = 0;
      wr(BASE + 32'h8, 32'h62);
      wr(BASE + 32'h8, 32'h63);
      wr(BASE + 32'h8, 32'h64);
      tb_rdy = 1;
      store_until(8'h64);
      drain();

      wr(BASE + 32'h10, 32'h0);
      for (int i = 0; i < 3; i++) wr(BASE + 32'h8, 32'h30 + i);
      drain();
      rd(BASE + 32'h10);
      wr(BASE + 32'h10, 32'hFFFF_FFFF);
      rd(BASE + 32'h10);

      step(1'b1, 1'b1, BASE + 32'h8, 32'hAA, 1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b1, BASE, 32'h0, 1'b0, 1'b0, 8'h00);
      rd(BASE + 32'h14);
      rd(32'h9000_0000);
      rd(BASE + 32'h2);
      wr(BASE + 32'h14, 32'h77);
      wr(32'h9000_0008, 32'h78);
      drain();

      for (int i = 0; i < 400; i++) begin
         automatic int unsigned kind = $urandom_range(0, 3);
         automatic logic [31:0] a = addrs[$urandom_range(0, 7)];
         tb_rdy = 1'($urandom_range(0, 1));
         tb_ov  = ($urandom_range(0, 2) == 0);
         tb_od  = 8'($urandom);
         if (kind == 1)      rd(a);
         else if (kind == 2) wr(a, $urandom);
         else                idle(1);
      end
      tb_ov = 0;
      drain();
      rd(BASE + 32'h10);

      tb_rdy = 0;
      for (int i = 0; i < 4; i++) wr(BASE + 32'h8, 32'hC0 + i);
      tb_ov = 1; tb_od = 8'h5A;
      rd(BASE);
      #1;
      memRd = 0; memWr = 1; addr = BASE + 32'h8; wdata = 32'hEE; DataInReady = 1;
      #1;
      chk("pre_reset_stall", {31'd0, stall}, 32'd1);
      #1;
      reset_n = 0;
      #1;
      rd_sb.delete();
      tx_sb.delete();
      occ = 0; m_rx_full = 0; m_rx_byte = '0; m_cnt = '0;
      chk("rst_DataInValid", {31'd0, DataInValid}, 32'd0);
      chk("rst_DataOutReady", {31'd0, DataOutReady}, 32'd1);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      memWr = 0; DataInReady = 0; DataOutValid = 0; tb_ov = 0; tb_rdy = 0;
      @(posedge clk);
      @(posedge clk);
      #1 reset_n = 1;
      @(posedge clk);
      rd(BASE);
      rd(BASE + 32'h4);
      rd(BASE + 32'h10);

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_mmio_ctrl.md
Name: uart_mmio_ctrl

Overview:
Memory-mapped controller between the CPU data-memory port and the UART core.
- Decodes CPU loads/stores in the 0x8000_00xx window.
- Buffers outgoing bytes in a small TX FIFO and drains it into the UART transmitter via ready/valid.
- Holds one received byte for the CPU.
- Stalls the pipeline on a store to a full TX FIFO.
- Returns registered load data, aligned with the synchronous data memory.

Parameters:
- TX_DEPTH, 4, TX FIFO entries; power of two, 2..16.
- ADDR_BASE, 32'h80000000, base of the UART register window.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- addr  in  32  CPU data address.
- memRd  in  1  CPU load strobe.
- memWr  in  1  CPU store strobe.
- wdata  in  32  CPU store data; only [7:0] used.
- rdata  out  32  load data, valid the cycle after the load.
- stall  out  1  CPU must hold addr/memWr/wdata this cycle.
- DataIn  out  8  byte to UART transmitter.
- DataInValid  out  1  DataIn valid.
- DataInReady  in  1  transmitter accepts DataIn.
- DataOut  in  8  byte from UART receiver.
- DataOutValid  in  1  DataOut valid.
- DataOutReady  out  1  controller can accept DataOut.

Behaviour:
- Reset (async, reset_n=0) clears the following: TX FIFO pointers/count, rx_full, rx_buf=0, rdata=0, stall=0, DataInValid=0, DataOutReady=1. Queued TX bytes are discarded.
- Register map, offsets from ADDR_BASE:
  - +0x0 read: {31'b0, tx_not_full}.
  - +0x4 read: {31'b0, rx_full}.
  - +0x8 write: push wdata[7:0] to TX FIFO.
  - +0xC read: {{24{rx_buf[7]}}, rx_buf} (sign-extended) if rx_full, else 0; pops rx_full.
  - All other offsets: read 0, write ignored.
- Load latency: rdata is registered from the addr/memRd decode and appears one cycle later. With no load, rdata returns to 0 next cycle.
- memRd and memWr both high is illegal; the store is executed and the read returns 0.
- TX FIFO:
  - DataInValid = !tx_empty; DataIn = head entry (registered storage, no combinational path from wdata).
  - Pop on DataInValid & DataInReady.
  - Push on store to +0x8 when not full.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pointers wrap mod TX_DEPTH; count is log2(TX_DEPTH)+1 bits.
- Stall: stall = memWr & (addr==+0x8) & tx_full, combinational.
  - A pop in the same cycle does not release the stall; the push lands the following cycle.
  - No other access stalls.
- RX holding register:
  - DataOutReady = !rx_full.
  - Capture DataOut into rx_buf and set rx_full on DataOutValid & DataOutReady.
  - Read of +0xC clears rx_full at the clock edge.
  - Capture and pop cannot coincide: capture requires empty, pop is effective only when full.
  - Read of +0xC while empty returns 0 and has no side effect.
- Reset asserted mid-transfer: DataInValid drops immediately, asynchronously. The UART core tolerates a withdrawn valid.

Optional Feature:
- Macro UART_TX_CNT_EN.
- Defined: 32-bit tx_count increments on every TX pop and wraps at 2^32.
  - Read at +0x10, registered like the other reads.
  - Any store to +0x10 clears it; a store wins over a simultaneous increment.
  - Reset value 0.
- Not defined: no counter; +0x10 reads 0 and writes are ignored.

Decomposition:
- Package uart_mmio_pkg holds:
  - register offset constants UART_CTRL_OFS=0x0, UART_STAT_OFS=0x4, UART_TX_OFS=0x8, UART_RX_OFS=0xC, UART_CNT_OFS=0x10;
  - status bit index constants;
  - a function for sign-extending 8->32.
- One sub-module, uart_tx_fifo: parametric depth, push/pop/full/empty/head, async active-low reset.
- Address decode, RX holding register, stall and rdata register stay in uart_mmio_ctrl.

Test Plan:
- Reset check: reset_n=0 mid-operation -> DataInValid=0, DataOutReady=1, rdata=0, stall=0 immediately. Read +0x0 after release -> rdata=1 next cycle.
- TX fill: 5 stores 0x41..0x45 to 0x80000008 with DataInReady=0, TX_DEPTH=4 -> stall=1 on 5th store only. Raise DataInReady -> DataIn sequence 0x41,0x42,0x43,0x44,0x45, stall drops, FIFO empties, DataInValid=0.
- RX sign extension: DataOut=0x9C with DataOutValid=1 -> DataOutReady falls. Read 0x80000004 -> 1. Read 0x8000000C -> rdata=0xFFFFFF9C next cycle. Re-read 0x80000004 -> 0.
- RX backpressure: second byte 0x12 offered while full -> not captured until after the +0xC read. Next read returns 0x00000012.
- Push/pop collision: FIFO holds 2 entries, store 0x55 in the same cycle as a pop -> count stays 2, ordering preserved.
- UART_TX_CNT_EN: send 3 bytes -> read 0x80000010 = 3. Store to 0x80000010 -> read = 0. Without the macro, the same reads return 0.
